load_store_unit: RTL and testbench

Load/store unit between the execute stage (ALU address result) and the word-organised synchronous data memory. It accepts one RV32I load or store per handshake and generates word addresses, byte enables and lane-shifted write data. Accesses that straddle a word boundary are split into two memory accesses. Load data is reassembled and sign- or zero-extended into a 32-bit writeback value.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 43 ++++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, size masks and funct3 helpers for the load/store unit
package lsu_pkg;

  // RV32I load/store width codes carried on funct3
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FIRST,
    ST_SECOND,
    ST_WAIT,
    ST_RESP
  } state_e;

  // Byte-lane masks for an access that starts at lane 0
  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0011;
  localparam logic [3:0] SZ_W = 4'b1111;

  // Lane mask for a funct3; zero for encodings that are not loads/stores
  function automatic logic [3:0] size_mask(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_mask = SZ_B;
      F3_H, F3_HU: size_mask = SZ_H;
      F3_W:        size_mask = SZ_W;
      default:     size_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic funct3_legal(input logic [2:0] funct3);
    funct3_legal = (size_mask(funct3) != 4'b0000);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane shifting for stores and extraction/extension for loads
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] word0,
  input  logic [31:0] word1,
  output logic [7:0]  be8,
  output logic [63:0] wdata64,
  output logic        split,
  output logic [31:0] rdata
);

  logic [3:0]  mask;
  logic [31:0] wdata_sized;
  logic [31:0] lane;

  // Store path: trim the data to the access size, then slide mask and data up by the byte offset
  always_comb begin
    mask        = size_mask(funct3);
    wdata_sized = wdata & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
    be8         = 8'({4'b0000, mask} << off);
    wdata64     = {32'h0, wdata_sized} << {off, 3'b000};
    // any lane pushed past byte 3 means the access touches the next word
    split       = |be8[7:4];
  end

  // Load path: bring the addressed byte down to lane 0 across the two-word window, then extend
  always_comb begin
    lane = 32'({word1, word0} >> {off, 3'b000});
    case (funct3)
      F3_B:    rdata = {{24{lane[7]}}, lane[7:0]};
      F3_H:    rdata = {{16{lane[15]}}, lane[15:0]};
      F3_W:    rdata = lane;
      F3_BU:   rdata = {24'h0, lane[7:0]};
      F3_HU:   rdata = {16'h0, lane[15:0]};
      default: rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with split-access support for misaligned requests
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        split_q;
  logic [31:0] word0_q;

  logic [2:0]  sel_f3;
  logic [1:0]  sel_off;
  logic [31:0] sel_wdata;
  logic [31:0] ld_word0;
  logic [31:0] ld_word1;
  logic [7:0]  be8;
  logic [63:0] wdata64;
  logic        split;
  logic [31:0] ld_data;

  // In IDLE the aligner looks at the live request so the first access can be registered on accept
  always_comb begin
    sel_f3    = (state == ST_IDLE) ? req_funct3       : f3_q;
    sel_off   = (state == ST_IDLE) ? req_addr[1:0]    : addr_q[1:0];
    sel_wdata = (state == ST_IDLE) ? req_wdata        : wdata_q;
    // in WAIT the bus carries the last word: word1 of a split, or the only word otherwise
    ld_word0  = split_q ? word0_q   : mem_rdata;
    ld_word1  = split_q ? mem_rdata : 32'h0;
  end

  lsu_align u_align (
    .funct3  (sel_f3),
    .off     (sel_off),
    .wdata   (sel_wdata),
    .word0   (ld_word0),
    .word1   (ld_word1),
    .be8     (be8),
    .wdata64 (wdata64),
    .split   (split),
    .rdata   (ld_data)
  );

  // Request FSM; memory and response outputs are registered one state ahead
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'h0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      store_q    <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      split_q    <= 1'b0;
      word0_q    <= 32'h0;
    end else begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'h0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      resp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            store_q   <= req_store;
            f3_q      <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            split_q   <= split;
            req_ready <= 1'b0;
            if (!funct3_legal(req_funct3)) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state     <= ST_FIRST;
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_be    <= be8[3:0];
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= wdata64[31:0];
            end
          end
        end
        ST_FIRST: begin
          if (split_q) begin
            state     <= ST_SECOND;
            mem_req   <= 1'b1;
            mem_we    <= store_q;
            mem_be    <= be8[7:4];
            // word index wraps naturally at the top of the address space
            mem_addr  <= {addr_q[31:2] + 30'd1, 2'b00};
            mem_wdata <= wdata64[63:32];
          end else begin
            state <= ST_WAIT;
          end
        end
        ST_SECOND: begin
          word0_q <= mem_rdata;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          resp_rdata <= store_q ? 32'h0 : ld_data;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= ST_RESP;
        end
        ST_RESP: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench with byte-level reference memory for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;

  load_store_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory seen by the DUT, and the byte-addressed reference memory
  logic [31:0] wmem [logic [29:0]];
  logic [7:0]  rmem [logic [31:0]];

  // Accesses observed during the current operation
  logic [31:0] acc_addr [$];
  logic [3:0]  acc_be [$];
  logic [31:0] acc_wdata [$];
  logic        acc_we [$];

  function automatic logic [31:0] wread(input logic [29:0] wa);
    if (wmem.exists(wa)) return wmem[wa];
    return 32'h0;
  endfunction

  function automatic logic [7:0] rbyte(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return 8'h0;
  endfunction

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    wmem[a[31:2]] = v;
    for (int i = 0; i < 4; i++) rmem[{a[31:2], 2'b00} + 32'(i)] = v[8*i +: 8];
  endtask

  // Synchronous memory: read data appears the cycle after the request
  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        logic [31:0] w;
        w = wread(mem_addr[31:2]);
        for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
        wmem[mem_addr[31:2]] = w;
      end else begin
        mem_rdata <= wread(mem_addr[31:2]);
      end
    end
  end

  function automatic int ref_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = ref_size(f3);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(rbyte(a + 32'(i))) << (8 * i));
    if (f3 == 3'b000 && v[7])  v = v | 32'hFFFFFF00;
    if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = ref_size(f3);
    for (int i = 0; i < n; i++) rmem[a + 32'(i)] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[8*i +: 8] = rbyte({a[31:2], 2'b00} + 32'(i));
    return v;
  endfunction

  // Issue one request and collect its response, latency and memory accesses
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err,
                       output int cyc);
    int guard;
    acc_addr.delete(); acc_be.delete(); acc_wdata.delete(); acc_we.delete();
    rd = 32'hDEADBEEF;
    err = 1'bx;
    cyc = -1;
    @(negedge clk);
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      total_cnt++;
      $display("FAIL ready_wait: req_ready=%0b required 1", req_ready);
      return;
    end
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_store = $urandom; req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (mem_req) begin
        acc_addr.push_back(mem_addr); acc_be.push_back(mem_be);
        acc_wdata.push_back(mem_wdata); acc_we.push_back(mem_we);
      end
      if (resp_valid) begin
        rd = resp_rdata; err = resp_err; cyc = c;
        break;
      end
    end
    if (cyc < 0) begin
      total_cnt++;
      $display("FAIL resp_timeout: no resp_valid within 12 cycles, addr=%h f3=%0d", a, f3);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({req_ready, resp_valid, resp_err, mem_req, mem_we} !== 5'b10000) begin
      $display("FAIL reset_ctrl: ready/valid/err/req/we=%b required 10000",
               {req_ready, resp_valid, resp_err, mem_req, mem_we});
    end else pass_cnt++;
    total_cnt++;
    if ({mem_be, mem_addr, mem_wdata, resp_rdata} !== 100'h0) begin
      $display("FAIL reset_data: be=%h addr=%h wdata=%h rdata=%h required 0",
               mem_be, mem_addr, mem_wdata, resp_rdata);
    end else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] rd;
    logic err;
    int cyc;
    set_word(32'h100, 32'h12345678);
    do_op(1'b0, 3'b010, 32'h100, 32'h0, rd, err, cyc);
    total_cnt++;
    if (acc_addr.size() != 1 || acc_addr[0] !== 32'h100 || acc_be[0] !== 4'b1111 || acc_we[0] !== 1'b0)
      $display("FAIL lw_access: count=%0d addr=%h be=%b we=%b required 1 100 1111 0",
               acc_addr.size(), acc_addr[0], acc_be[0], acc_we[0]);
    else pass_cnt++;
    total_cnt++;
    if (cyc != 3 || rd !== 32'h12345678)
      $display("FAIL lw_resp: cycle=%0d rdata=%h required 3 12345678", cyc, rd);
    else pass_cnt++;

    set_word(32'h100, 32'h80FF7F01);
    begin
      logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b001};
      logic [31:0] as  [4] = '{32'h103, 32'h103, 32'h100, 32'h102};
      logic [31:0] exs [4] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'hFFFF80FF};
      for (int i = 0; i < 4; i++) begin
        do_op(1'b0, f3s[i], as[i], 32'h0, rd, err, cyc);
        total_cnt++;
        if (rd !== exs[i] || err !== 1'b0 || cyc != 3)
          $display("FAIL ext_load%0d: rdata=%h err=%b cycle=%0d required %h 0 3", i, rd, err, cyc, exs[i]);
        else pass_cnt++;
      end
    end

    do_op(1'b1, 3'b010, 32'h102, 32'hAABBCCDD, rd, err, cyc);
    ref_store(3'b010, 32'h102, 32'hAABBCCDD);
    total_cnt++;
    if (acc_addr.size() != 2)
      $display("FAIL sw_split_count: accesses=%0d required 2", acc_addr.size());
    else begin
      pass_cnt++;
      total_cnt++;
      if (acc_addr[0] !== 32'h100 || acc_be[0] !== 4'b1100 || acc_wdata[0] !== 32'hCCDD0000 || acc_we[0] !== 1'b1)
        $display("FAIL sw_split_first: addr=%h be=%b wdata=%h we=%b required 100 1100 ccdd0000 1",
                 acc_addr[0], acc_be[0], acc_wdata[0], acc_we[0]);
      else pass_cnt++;
      total_cnt++;
      if (acc_addr[1] !== 32'h104 || acc_be[1] !== 4'b0011 || acc_wdata[1] !== 32'h0000AABB || acc_we[1] !== 1'b1)
        $display("FAIL sw_split_second: addr=%h be=%b wdata=%h we=%b required 104 0011 0000aabb 1",
                 acc_addr[1], acc_be[1], acc_wdata[1], acc_we[1]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cyc != 4 || rd !== 32'h0 || err !== 1'b0)
      $display("FAIL sw_split_resp: cycle=%0d rdata=%h err=%b required 4 0 0", cyc, rd, err);
    else pass_cnt++;

    set_word(32'hFFFFFFFC, 32'h34000000);
    set_word(32'h00000000, 32'h00000092);
    do_op(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, rd, err, cyc);
    total_cnt++;
    if (acc_addr.size() != 2 || acc_addr[0] !== 32'hFFFFFFFC || acc_addr[1] !== 32'h0)
      $display("FAIL wrap_access: count=%0d addr0=%h addr1=%h required 2 fffffffc 0",
               acc_addr.size(), acc_addr[0], acc_addr[1]);
    else pass_cnt++;
    total_cnt++;
    if (rd !== 32'hFFFF9234 || cyc != 4)
      $display("FAIL wrap_resp: rdata=%h cycle=%0d required ffff9234 4", rd, cyc);
    else pass_cnt++;
  endtask

  task automatic test_illegal();
    logic [31:0] rd;
    logic err;
    int cyc;
    logic [2:0] bad [3] = '{3'b011, 3'b110, 3'b111};
    for (int i = 0; i < 3; i++) begin
      do_op(i[0], bad[i], 32'h100, 32'hFFFFFFFF, rd, err, cyc);
      total_cnt++;
      if (acc_addr.size() != 0 || cyc != 1 || err !== 1'b1 || rd !== 32'h0)
        $display("FAIL illegal_f3_%0d: accesses=%0d cycle=%0d err=%b rdata=%h required 0 1 1 0",
                 bad[i], acc_addr.size(), cyc, err, rd);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    logic err;
    int cyc;
    int bad_events;
    set_word(32'h300, 32'h11223344);
    set_word(32'h304, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h301; req_wdata = 32'h0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h304)
      $display("FAIL mid_second: mem_req=%b addr=%h required 1 304", mem_req, mem_addr);
    else pass_cnt++;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    total_cnt++;
    if ({req_ready, resp_valid, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== {2'b10, 2'b00, 4'h0, 64'h0})
      $display("FAIL mid_reset_out: ready=%b valid=%b req=%b be=%h addr=%h required 1 0 0 0 0",
               req_ready, resp_valid, mem_req, mem_be, mem_addr);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    bad_events = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid || mem_req) bad_events++;
    end
    total_cnt++;
    if (bad_events != 0)
      $display("FAIL mid_reset_quiet: stray events=%0d required 0", bad_events);
    else pass_cnt++;
    do_op(1'b0, 3'b010, 32'h300, 32'h0, rd, err, cyc);
    total_cnt++;
    if (rd !== 32'h11223344 || cyc != 3 || err !== 1'b0)
      $display("FAIL post_reset_lw: rdata=%h cycle=%0d err=%b required 11223344 3 0", rd, cyc, err);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic err;
    int cyc;
    int late;
    late = 0;
    for (int i = 0; i < 6; i++) begin
      do_op(1'b0, 3'b010, 32'h100, 32'h0, rd, err, cyc);
      if (req_ready !== 1'b0) late++;
      @(negedge clk);
      if (req_ready !== 1'b1) late++;
      #0;
    end
    total_cnt++;
    if (late != 0)
      $display("FAIL back_to_back_ready: bad ready samples=%0d required 0", late);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] rd, a, wd, exp_rd;
    logic [2:0] f3;
    logic st, err, legal, exp_split;
    int cyc, n, errs_rd, errs_lat, errs_acc, errs_mem, exp_cyc;
    logic [2:0] legal_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    errs_rd = 0; errs_lat = 0; errs_acc = 0; errs_mem = 0;
    for (int w = 0; w < 16; w++) set_word(32'h200 + 32'(4 * w), $urandom);
    for (int w = 0; w < 4; w++) set_word(32'hFFFFFFF0 + 32'(4 * w), $urandom);
    set_word(32'h0, $urandom);
    for (int i = 0; i < 250; i++) begin
      f3 = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : legal_f3[$urandom_range(0, 4)];
      st = $urandom_range(0, 2) == 0;
      if (st && f3[2]) f3 = {1'b0, f3[1:0]};
      a = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                      : (32'h200 + 32'($urandom_range(0, 59)));
      wd = $urandom;
      n = ref_size(f3);
      legal = (n != 0);
      exp_split = legal && (32'(a[1:0]) + 32'(n) > 4);
      exp_cyc = !legal ? 1 : (exp_split ? 4 : 3);
      exp_rd = (legal && !st) ? ref_load(f3, a) : 32'h0;
      do_op(st, f3, a, wd, rd, err, cyc);
      if (rd !== exp_rd || err !== !legal) begin
        errs_rd++;
        if (errs_rd < 5) $display("FAIL rand_resp: op%0d st=%b f3=%0d addr=%h rdata=%h err=%b required %h %b",
                                  i, st, f3, a, rd, err, exp_rd, !legal);
      end
      if (cyc != exp_cyc) errs_lat++;
      if (acc_addr.size() != (legal ? (exp_split ? 2 : 1) : 0) ||
          (legal && acc_addr[0] !== {a[31:2], 2'b00})) errs_acc++;
      if (legal && st) begin
        ref_store(f3, a, wd);
        if (wread(a[31:2]) !== ref_word(a) ||
            wread(a[31:2] + 30'd1) !== ref_word({a[31:2] + 30'd1, 2'b00})) errs_mem++;
      end
    end
    total_cnt++;
    if (errs_rd != 0) $display("FAIL rand_data: mismatching ops=%0d required 0", errs_rd);
    else pass_cnt++;
    total_cnt++;
    if (errs_lat != 0) $display("FAIL rand_latency: wrong latency ops=%0d required 0", errs_lat);
    else pass_cnt++;
    total_cnt++;
    if (errs_acc != 0) $display("FAIL rand_access: wrong access pattern ops=%0d required 0", errs_acc);
    else pass_cnt++;
    total_cnt++;
    if (errs_mem != 0) $display("FAIL rand_memory: wrong memory contents ops=%0d required 0", errs_mem);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
